// File: rtl/vs_argmax_stream.sv
// Streaming per-frame arg-max / arg-min / abs-max reduction.
// Accepts FRAME_LEN signed samples one per cycle, then presents the winning
// value and its 0-based index until the downstream takes it.
module vs_argmax_stream #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_value,
    output logic [IDX_W-1:0] o_out_index
);

    typedef enum logic {
        StAccum  = 1'b0,
        StOutput = 1'b1
    } state_t;

    localparam logic [1:0] ModeMax = 2'd0;
    localparam logic [1:0] ModeAbs = 2'd1;
    localparam logic [1:0] ModeMin = 2'd2;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_count;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_acc;
    logic [IDX_W-1:0] r_index;

    logic             w_ready;
    logic             w_valid;
    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic [1:0]       w_mode_norm;
    logic [1:0]       w_mode_eff;
    logic [WIDTH:0]   w_in_ext;
    logic [WIDTH:0]   w_mag_wide;
    logic [WIDTH-1:0] w_cand;
    logic             w_better;

    assign w_accept = i_in_valid & w_ready;
    assign w_first  = (r_count == '0);
    assign w_last   = (r_count == LastIdx);

    // Reserved mode 3 folds onto signed max before it is ever latched.
    assign w_mode_norm = (i_mode == 2'd3) ? ModeMax : i_mode;

    // Sample 0 uses the live mode; the rest of the frame uses the latched one.
    assign w_mode_eff = w_first ? w_mode_norm : r_mode;

    // One extra bit so the most negative input negates to 2^(WIDTH-1) cleanly.
    assign w_in_ext   = {i_in_data[WIDTH-1], i_in_data};
    assign w_mag_wide = w_in_ext[WIDTH] ? (~w_in_ext + {{WIDTH{1'b0}}, 1'b1}) : w_in_ext;

    assign w_cand = (w_mode_eff == ModeAbs) ? w_mag_wide[WIDTH-1:0] : i_in_data;

    // Strictly-better test against the running winner; ties keep the earlier index.
    always_comb begin
        w_better = 1'b0;
        case (w_mode_eff)
            ModeAbs: w_better = (w_mag_wide > {1'b0, r_acc});
            ModeMin: w_better = ($signed(i_in_data) < $signed(r_acc));
            default: w_better = ($signed(i_in_data) > $signed(r_acc));
        endcase
    end

    // FSM next state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            StAccum: begin
                w_ready = 1'b1;
                if (i_in_valid && w_last) begin
                    w_state_next = StOutput;
                end
            end
            StOutput: begin
                w_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_next = StAccum;
                end
            end
            default: w_state_next = StAccum;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StAccum;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sample counter, latched mode and running winner; only accepted samples move them.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
            r_mode  <= ModeMax;
            r_acc   <= '0;
            r_index <= '0;
        end else if (w_accept) begin
            r_count <= w_last ? '0 : (r_count + IDX_W'(1));
            if (w_first) begin
                r_mode  <= w_mode_norm;
                r_acc   <= w_cand;
                r_index <= '0;
            end else if (w_better) begin
                r_acc   <= w_cand;
                r_index <= r_count;
            end
        end
    end

    // Handshakes are forced low while reset is held so nothing moves during it.
    assign o_in_ready  = w_ready & ~i_reset;
    assign o_out_valid = w_valid & ~i_reset;
    assign o_out_value = r_acc;
    assign o_out_index = r_index;

endmodule
